// File: rtl/pconv_c1_drain_pkg.sv
// Shared types and default geometry for the first-layer pointwise-conv drain.
package pconv_c1_drain_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam int unsigned DEF_N          = 16;
    localparam int unsigned DEF_INPUT_SIZE = 6;
    localparam int unsigned DEF_CHANNEL    = 32;

    localparam int unsigned PIXELS = DEF_INPUT_SIZE * DEF_INPUT_SIZE;
    localparam int unsigned CH_W   = $clog2(DEF_CHANNEL);
    localparam int unsigned PIX_W  = $clog2(PIXELS);

endpackage

// File: rtl/pconv_c1_drain_fbuf.sv
// Frame buffer: one full-width write port, combinational single-channel read.
module pconv_c1_fbuf
    import pconv_c1_drain_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned CHANNEL = DEF_CHANNEL,
    parameter int unsigned WORDS   = PIXELS,
    parameter int unsigned AW      = PIX_W,
    parameter int unsigned SW      = CH_W
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [CHANNEL*N-1:0] wr_data,
    input  logic [AW-1:0]        rd_addr,
    input  logic [SW-1:0]        rd_sel,
    output logic [N-1:0]         rd_data
);

    logic [CHANNEL-1:0][N-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = mem[rd_addr][rd_sel];
    end

endmodule

// File: rtl/pconv_c1_drain.sv
// Collects a full frame of channel vectors, then streams it channel-major
// over a valid/ready port with registered sideband indices.
module pconv_c1_drain
    import pconv_c1_drain_pkg::*;
#(
    parameter int unsigned N          = DEF_N,
    parameter int unsigned INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int unsigned CHANNEL    = DEF_CHANNEL
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       din_vld,
    input  logic [CHANNEL*N-1:0]                       din,
    output logic                                       busy,
    output logic [N-1:0]                               dout,
    output logic                                       dout_vld,
    input  logic                                       dout_rdy,
    output logic [$clog2(CHANNEL)-1:0]                 dout_ch,
    output logic [$clog2(INPUT_SIZE*INPUT_SIZE)-1:0]   dout_pix,
    output logic                                       dout_end,
    output logic                                       ovf
);

    localparam int unsigned NPIX = INPUT_SIZE * INPUT_SIZE;
    localparam int unsigned CW   = $clog2(CHANNEL);
    localparam int unsigned PW   = $clog2(NPIX);

    state_t         state;
    state_t         state_next;
    logic [PW-1:0]  wcnt;
    logic [CW-1:0]  rd_ch;
    logic [PW-1:0]  rd_pix;
    logic           rd_done;
    logic           wr_en;
    logic           wr_last;
    logic           load;
    logic           take;
    logic           rd_last;
    logic           fire_end;
    logic [N-1:0]   rd_data;

    pconv_c1_fbuf #(
        .N       (N),
        .CHANNEL (CHANNEL),
        .WORDS   (NPIX),
        .AW      (PW),
        .SW      (CW)
    ) u_fbuf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wcnt),
        .wr_data (din),
        .rd_addr (rd_pix),
        .rd_sel  (rd_ch),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        wr_en      = 1'b0;
        wr_last    = 1'b0;
        take       = 1'b0;
        load       = !dout_vld || dout_rdy;
        rd_last    = (rd_ch == CW'(CHANNEL - 1)) && (rd_pix == PW'(NPIX - 1));
        fire_end   = dout_vld && dout_rdy && dout_end;
        case (state)
            FILL: begin
                wr_en   = din_vld;
                wr_last = din_vld && (wcnt == PW'(NPIX - 1));
                if (wr_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                take = load && !rd_done;
                if (fire_end) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (wr_last) begin
            wcnt <= '0;
        end else if (wr_en) begin
            wcnt <= wcnt + PW'(1);
        end
    end

    // rd_done marks the last value as loaded so the pointers never re-read the
    // buffer while the final value waits for its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ch   <= '0;
            rd_pix  <= '0;
            rd_done <= 1'b0;
        end else if (fire_end) begin
            rd_ch   <= '0;
            rd_pix  <= '0;
            rd_done <= 1'b0;
        end else if (take) begin
            if (rd_last) begin
                rd_done <= 1'b1;
            end
            if (rd_pix == PW'(NPIX - 1)) begin
                rd_pix <= '0;
                rd_ch  <= rd_ch + CW'(1);
            end else begin
                rd_pix <= rd_pix + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_ch  <= '0;
            dout_pix <= '0;
            dout_end <= 1'b0;
        end else if (take) begin
            dout     <= rd_data;
            dout_vld <= 1'b1;
            dout_ch  <= rd_ch;
            dout_pix <= rd_pix;
            dout_end <= rd_last;
        end else if (dout_vld && dout_rdy) begin
            dout_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == DRAIN && din_vld) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pconv_c1_drain.sv
// Randomized scoreboard bench for pconv_c1_drain against a frame-array model.
module tb_pconv_c1_drain;

    localparam int N = 16;
    localparam int S = 6;
    localparam int C = 32;
    localparam int P = S * S;

    typedef struct packed {
        logic [N-1:0] d;
        logic [4:0]   ch;
        logic [5:0]   pix;
        logic         e;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           din_vld;
    logic [C*N-1:0] din;
    logic           busy;
    logic [N-1:0]   dout;
    logic           dout_vld;
    logic           dout_rdy;
    logic [4:0]     dout_ch;
    logic [5:0]     dout_pix;
    logic           dout_end;
    logic           ovf;

    exp_t         sb[$];
    logic [N-1:0] fm [P][C];
    int           n_chk  = 0;
    int           n_fail = 0;
    int           n_out  = 0;
    bit           rand_rdy = 1'b0;

    pconv_c1_drain #(
        .N          (N),
        .INPUT_SIZE (S),
        .CHANNEL    (C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din_vld  (din_vld),
        .din      (din),
        .busy     (busy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .dout_ch  (dout_ch),
        .dout_pix (dout_pix),
        .dout_end (dout_end),
        .ovf      (ovf)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: always high, or a coin flip per cycle when stalls are enabled.
    initial begin
        dout_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    initial begin : mon
        exp_t         e;
        logic         stalled;
        logic [27:0]  held;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_vld", 64'(dout_vld), 64'd1);
                    chk("stall_hold", 64'({dout, dout_ch, dout_pix, dout_end}), 64'(held));
                end
                if (dout_vld && dout_rdy) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_out: got ch %0d pix %0d data %0h with empty scoreboard",
                                 dout_ch, dout_pix, dout);
                    end else begin
                        e = sb.pop_front();
                        chk("dout", 64'(dout), 64'(e.d));
                        chk("dout_ch", 64'(dout_ch), 64'(e.ch));
                        chk("dout_pix", 64'(dout_pix), 64'(e.pix));
                        chk("dout_end", 64'(dout_end), 64'(e.e));
                    end
                    n_out++;
                end
                stalled = dout_vld && !dout_rdy;
                held    = {dout, dout_ch, dout_pix, dout_end};
            end
        end
    end

    task automatic send_frame(input bit ramp);
        logic [C*N-1:0] v;
        for (int p = 0; p < P; p++) begin
            for (int c = 0; c < C; c++) begin
                fm[p][c] = ramp ? 16'(p * 64 + c) : 16'($urandom);
                v[c*N +: N] = fm[p][c];
            end
            din     = v;
            din_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        din_vld = 1'b0;
        for (int c = 0; c < C; c++) begin
            for (int p = 0; p < P; p++) begin
                sb.push_back('{d: fm[p][c], ch: 5'(c), pix: 6'(p), e: (c == C - 1 && p == P - 1)});
            end
        end
    endtask

    task automatic send_partial(input int cnt);
        for (int p = 0; p < cnt; p++) begin
            din     = {16{$urandom}};
            din_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        din_vld = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((busy || sb.size() != 0) && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_drain_done"}, 64'(cyc < 8000), 64'd1);
    endtask

    task automatic wait_outputs(input int cnt);
        int cyc = 0;
        while (n_out < cnt && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_outputs", 64'(cyc < 8000), 64'd1);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_busy"}, 64'(busy), 64'd0);
        chk({name, "_vld"}, 64'(dout_vld), 64'd0);
        chk({name, "_data"}, 64'({dout, dout_ch, dout_pix, dout_end}), 64'd0);
        chk({name, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    task automatic pulse_reset(input string name);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero(name);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        din_vld = 1'b0;
        din     = '0;
        #12;
        check_zero("reset");
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame with ready held high, plus first-output latency.
        n_out = 0;
        send_frame(1'b1);
        @(negedge clk);
        chk("ramp_busy_after_last", 64'(busy), 64'd1);
        chk("ramp_vld_not_yet", 64'(dout_vld), 64'd0);
        @(negedge clk);
        chk("ramp_vld_rises", 64'(dout_vld), 64'd1);
        wait_drain("ramp");
        chk("ramp_count", 64'(n_out), 64'(C * P));

        // Random backpressure.
        rand_rdy = 1'b1;
        n_out = 0;
        send_frame(1'b0);
        wait_drain("stall");
        chk("stall_count", 64'(n_out), 64'(C * P));

        // Two frames back-to-back: second frame starts the cycle busy falls.
        send_frame(1'b0);
        begin
            int cyc = 0;
            while (busy && cyc < 8000) begin
                @(negedge clk);
                cyc++;
            end
            chk("b2b_busy_fall", 64'(cyc < 8000), 64'd1);
        end
        send_frame(1'b0);
        wait_drain("b2b");
        chk("b2b_ovf", 64'(ovf), 64'd0);

        // Write during drain is dropped and flags overflow.
        rand_rdy = 1'b0;
        n_out = 0;
        send_frame(1'b0);
        wait_outputs(50);
        @(posedge clk);
        #1;
        din     = {16{$urandom}};
        din_vld = 1'b1;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        @(negedge clk);
        chk("ovf_set", 64'(ovf), 64'd1);
        wait_drain("ovf");
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Reset mid-drain after 100 outputs.
        n_out = 0;
        send_frame(1'b0);
        wait_outputs(100);
        pulse_reset("rst_drain");
        send_frame(1'b1);
        wait_drain("after_rst_drain");

        // Reset mid-fill after 10 vectors.
        rand_rdy = 1'b1;
        send_partial(10);
        pulse_reset("rst_fill");
        send_frame(1'b0);
        wait_drain("after_rst_fill");
        chk("final_ovf", 64'(ovf), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
